// File: rtl/rrg_param_loader.sv
// Host-side parameter loader for the ramp/rate generator: serialises one
// setpoint command onto reg_control/reg_0..3 and reports setpoint settling.
// Ports:
//   clk_slow, nReset              clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_mask, cmd_*set            word mask and 64-bit parameter words
//   reg_control, reg_0..reg_3     code and 16-bit value slices to generator
//   busy, commit_pulse            sequence status, first-cycle commit strobe
//   Yis, Ris, settled             generator feedback and settle flag
module rrg_param_loader #(
    parameter int HOLD_CYCLES   = 2,
    parameter int GAP_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk_slow,
    input  logic               nReset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_mask,
    input  logic signed [63:0] cmd_yset,
    input  logic signed [63:0] cmd_rset,
    input  logic signed [63:0] cmd_riset,
    input  logic signed [63:0] cmd_roset,
    output logic [15:0]        reg_control,
    output logic [15:0]        reg_0,
    output logic [15:0]        reg_1,
    output logic [15:0]        reg_2,
    output logic [15:0]        reg_3,
    output logic               busy,
    output logic               commit_pulse,
    input  logic signed [63:0] Yis,
    input  logic signed [63:0] Ris,
    output logic               settled
);

    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CW-1:0] HLAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GLAST = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [SW-1:0] SMAX  = SW'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_COMMIT,
        S_CGAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0][63:0] words_q, words_d;
    logic             ymask_q, ymask_d;

    logic [15:0]      ctrl_q, ctrl_d;
    logic [63:0]      data_q, data_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             pulse_q, pulse_d;

    logic [1:0]       adv_idx;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r;
        if (m[0])      r = 2'd0;
        else if (m[1]) r = 2'd1;
        else if (m[2]) r = 2'd2;
        else           r = 2'd3;
        return r;
    endfunction

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= '0;
            words_q <= '0;
            ymask_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            words_q <= words_d;
            ymask_q <= ymask_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            pulse_q <= pulse_d;
        end
    end

    // pend holds the words still to be sent; the lowest one goes next
    assign adv_idx = lowest(pend_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        pend_d  = pend_q;
        words_d = words_q;
        ymask_d = ymask_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    words_d = {cmd_roset, cmd_riset, cmd_rset, cmd_yset};
                    ymask_d = cmd_mask[0];
                    if (cmd_mask != 4'd0) begin
                        state_d = S_LOAD;
                        idx_d   = lowest(cmd_mask);
                        pend_d  = cmd_mask & ~(4'b0001 << idx_d);
                    end else begin
                        state_d = S_COMMIT;
                        pend_d  = '0;
                    end
                end
            end
            S_LOAD, S_GAP: begin
                if ((state_q == S_LOAD && cnt_q == HLAST) ||
                    (state_q == S_GAP && cnt_q == GLAST)) begin
                    cnt_d = '0;
                    if (state_q == S_LOAD && GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else if (pend_q != 4'd0) begin
                        state_d = S_LOAD;
                        idx_d   = adv_idx;
                        pend_d  = pend_q & ~(4'b0001 << adv_idx);
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                if (cnt_q == HLAST) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? S_CGAP : S_IDLE;
                end
            end
            S_CGAP: begin
                if (cnt_q == GLAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered from the next state so they line up with it
        ctrl_d = '0;
        data_d = data_q;
        if (state_d == S_LOAD) begin
            ctrl_d = {14'd0, idx_d} + 16'd1;
            data_d = words_d[idx_d];
        end else if (state_d == S_COMMIT) begin
            ctrl_d = 16'd5;
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        pulse_d = (state_d == S_COMMIT) && (state_q != S_COMMIT);
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign commit_pulse = pulse_q;
    assign reg_control  = ctrl_q;
    assign reg_0        = data_q[15:0];
    assign reg_1        = data_q[31:16];
    assign reg_2        = data_q[47:32];
    assign reg_3        = data_q[63:48];

    logic [63:0]   yis_q, ris_q;
    logic          vld_q;
    logic [63:0]   cyset_q, cyset_d;
    logic [SW-1:0] mcnt_q, mcnt_d;
    logic          settled_q, settled_d;
    logic          match;

    // vld_q keeps the reset value of yis_q from counting as a sample
    assign match = vld_q && (yis_q == cyset_q) && (ris_q == 64'd0);

    always_comb begin
        cyset_d = cyset_q;
        mcnt_d  = mcnt_q;
        if (pulse_q) begin
            mcnt_d = '0;
            if (ymask_q) begin
                cyset_d = words_q[0];
            end
        end else if (!match) begin
            mcnt_d = '0;
        end else if (mcnt_q != SMAX) begin
            mcnt_d = mcnt_q + SW'(1);
        end
        // requiring the count to stay full lets a mismatch drop settled at once
        settled_d = (mcnt_q == SMAX) && (mcnt_d == SMAX);
    end

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            yis_q     <= '0;
            ris_q     <= '0;
            vld_q     <= 1'b0;
            cyset_q   <= '0;
            mcnt_q    <= '0;
            settled_q <= 1'b0;
        end else begin
            yis_q     <= Yis;
            ris_q     <= Ris;
            vld_q     <= 1'b1;
            cyset_q   <= cyset_d;
            mcnt_q    <= mcnt_d;
            settled_q <= settled_d;
        end
    end

    assign settled = settled_q;

endmodule

// File: tb/tb_rrg_param_loader.sv
// Testbench for rrg_param_loader: default instance plus a HOLD=1/GAP=0
// instance, checked against a code-sequence and settle-run model.
module tb_rrg_param_loader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        vld[2];
    logic [3:0]  mask;
    logic [63:0] wy, wr, wri, wro;
    logic [63:0] yis, ris;
    logic        rdy[2], bsy[2], pls[2], stl[2];
    logic [15:0] ctrl[2], r0[2], r1[2], r2[2], r3[2];

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] last[2];

    bit          cflag = 1'b0;
    bit          cupd = 1'b0;
    logic [63:0] cy = '0;
    logic [63:0] comm = '0;
    int          run = 0;
    bit          exp_s = 1'b0;

    always #5 clk = ~clk;

    rrg_param_loader u0 (
        .clk_slow(clk), .nReset(nReset),
        .cmd_valid(vld[0]), .cmd_ready(rdy[0]), .cmd_mask(mask),
        .cmd_yset(wy), .cmd_rset(wr), .cmd_riset(wri), .cmd_roset(wro),
        .reg_control(ctrl[0]), .reg_0(r0[0]), .reg_1(r1[0]),
        .reg_2(r2[0]), .reg_3(r3[0]), .busy(bsy[0]),
        .commit_pulse(pls[0]), .Yis(yis), .Ris(ris), .settled(stl[0])
    );

    rrg_param_loader #(
        .HOLD_CYCLES(1), .GAP_CYCLES(0), .SETTLE_CYCLES(4)
    ) u1 (
        .clk_slow(clk), .nReset(nReset),
        .cmd_valid(vld[1]), .cmd_ready(rdy[1]), .cmd_mask(mask),
        .cmd_yset(wy), .cmd_rset(wr), .cmd_riset(wri), .cmd_roset(wro),
        .reg_control(ctrl[1]), .reg_0(r0[1]), .reg_1(r1[1]),
        .reg_2(r2[1]), .reg_3(r3[1]), .busy(bsy[1]),
        .commit_pulse(pls[1]), .Yis(yis), .Ris(ris), .settled(stl[1])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd(input int d);
        return {r3[d], r2[d], r1[d], r0[d]};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 64'(rdy[d]), 64'd1);
    endtask

    // Issue one command, then check ncyc cycles of the expected code
    // stream (ncyc < 0: the whole stream plus the return to idle).
    task automatic go(input int d, input logic [3:0] m,
                      input logic [63:0] y, input logic [63:0] r,
                      input logic [63:0] ri, input logic [63:0] ro,
                      input bit hold, input int ncyc);
        logic [63:0] w[4];
        int codes[$];
        int h, g, n, prev, c;
        h = (d == 0) ? 2 : 1;
        g = (d == 0) ? 1 : 0;
        wait_ready(d);
        mask = m; wy = y; wr = r; wri = ri; wro = ro;
        vld[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) vld[d] = 1'b0;
        w[0] = y; w[1] = r; w[2] = ri; w[3] = ro;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                repeat (h) codes.push_back(i + 1);
                repeat (g) codes.push_back(0);
            end
        end
        repeat (h) codes.push_back(5);
        repeat (g) codes.push_back(0);
        n = (ncyc < 0) ? codes.size() : ncyc;
        prev = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            c = codes[k];
            if (c >= 1 && c <= 4) last[d] = w[c-1];
            check("code", 64'(ctrl[d]), 64'(c));
            check("data", rd(d), last[d]);
            check("commit_pulse", 64'(pls[d]), 64'(c == 5 && prev != 5));
            check("busy", 64'(bsy[d]), 64'd1);
            check("ready_low", 64'(rdy[d]), 64'd0);
            if (d == 0 && c == 5 && prev != 5) begin
                cflag = 1'b1;
                cupd  = m[0];
                cy    = y;
            end
            prev = c;
        end
        if (ncyc < 0) begin
            @(negedge clk);
            check("ready_back", 64'(rdy[d]), 64'd1);
            check("idle_busy", 64'(bsy[d]), 64'd0);
            check("idle_code", 64'(ctrl[d]), 64'd0);
        end
    endtask

    // Settle model: settled after an edge needs more than S consecutive
    // matching samples since the last commit or reset.
    initial begin
        forever begin
            @(posedge clk);
            if (!nReset) begin
                run = 0; comm = '0; exp_s = 1'b0; cflag = 1'b0;
            end else if (cflag) begin
                if (cupd) comm = cy;
                exp_s = 1'b0;
                run = (yis == comm && ris == 64'd0) ? 1 : 0;
                cflag = 1'b0;
            end else begin
                exp_s = (run >= S + 1);
                run = (yis == comm && ris == 64'd0) ? run + 1 : 0;
            end
            @(negedge clk);
            check("settled", 64'(stl[0]), 64'(exp_s));
        end
    end

    initial begin
        logic [3:0]  m;
        logic [63:0] y;
        vld[0] = 1'b0; vld[1] = 1'b0;
        mask = '0; wy = '0; wr = '0; wri = '0; wro = '0;
        yis = 64'd77; ris = 64'd1;
        last[0] = '0; last[1] = '0;

        repeat (3) @(negedge clk);
        check("rst_code", 64'(ctrl[0]), 64'd0);
        check("rst_data", rd(0), 64'd0);
        check("rst_ready", 64'(rdy[0]), 64'd0);
        check("rst_busy", 64'(bsy[0]), 64'd0);
        check("rst_pulse", 64'(pls[0]), 64'd0);
        check("rst_data_fast", rd(1), 64'd0);
        nReset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(rdy[0]), 64'd1);

        go(0, 4'hF, 64'h0000_0000_0001_2345, 64'h10, 64'd2, 64'd1, 1'b0, -1);
        go(0, 4'b0100, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, -1);

        go(0, 4'h0, rnd64(), rnd64(), rnd64(), rnd64(), 1'b1, -1);
        go(0, 4'h0, wy, wr, wri, wro, 1'b0, -1);

        go(0, 4'hF, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, 4);
        nReset = 1'b0;
        @(negedge clk);
        check("abort_code", 64'(ctrl[0]), 64'd0);
        check("abort_data", rd(0), 64'd0);
        check("abort_busy", 64'(bsy[0]), 64'd0);
        check("abort_pulse", 64'(pls[0]), 64'd0);
        nReset = 1'b1;
        last[0] = '0; last[1] = '0;
        repeat (20) begin
            @(negedge clk);
            check("abort_no5", 64'(ctrl[0] == 16'd5), 64'd0);
            check("abort_nopulse", 64'(pls[0]), 64'd0);
        end
        check("abort_ready", 64'(rdy[0]), 64'd1);

        yis = 64'hFFFF_FFFF_FFFF_FFFB; ris = 64'd0;
        go(0, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFB, rnd64(), rnd64(), rnd64(),
           1'b0, -1);
        repeat (8) @(negedge clk);
        check("settle_hi", 64'(stl[0]), 64'd1);
        yis = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        yis = 64'hFFFF_FFFF_FFFF_FFFB;
        repeat (2) @(negedge clk);
        check("settle_drop", 64'(stl[0]), 64'd0);
        repeat (8) @(negedge clk);
        ris = 64'd3;
        @(negedge clk);
        ris = 64'd0;
        repeat (8) @(negedge clk);
        go(0, 4'b0100, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, -1);
        repeat (8) @(negedge clk);
        check("settle_keep_yset", 64'(stl[0]), 64'd1);

        go(1, 4'hF, rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, -1);
        go(1, 4'($urandom), rnd64(), rnd64(), rnd64(), rnd64(), 1'b0, -1);

        for (int t = 0; t < 12; t++) begin
            m = 4'($urandom);
            y = rnd64();
            if ($urandom_range(0, 1) == 1) begin
                yis = y; ris = 64'd0;
            end else begin
                yis = rnd64(); ris = 64'($urandom_range(0, 1));
            end
            go(0, m, y, rnd64(), rnd64(), rnd64(), 1'b0, -1);
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
